// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode 7-segment scanner fed by packed BCD counters.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module bcd_display_scan #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [N_DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Active-high {g..a} pattern; anything outside 0..9 shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_dig_q;
  logic [N_DIGITS-1:0]   snap_dp_q;
  logic                  snap_en_s;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  in_blank_s;
  logic [N_DIGITS-1:0]   lz_blank_s;
  logic [3:0]            cur_dig_s;
  logic                  cur_hide_s;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank_s = 1'b0;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
      assign in_blank_s = (cnt_q < BLANK_C);
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is hidden when it and every digit above it are zero, unless its dp is lit.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank_s = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (snap_dig_q[4*i +: 4] == 4'h0);
      lz_blank_s[i] = zero_above & ~snap_dp_q[i];
    end
  end
`else
  assign lz_blank_s = '0;
`endif

  always_comb begin
    cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    idx_d     = idx_q;
    snap_en_s = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      snap_en_s = (idx_q == IDX_LAST);
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_comb begin
    cur_dig_s  = snap_dig_q[{idx_q, 2'b00} +: 4];
    cur_hide_s = lz_blank_s[idx_q];
    an_d       = '1;
    if (!in_blank_s && !cur_hide_s) begin
      an_d = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
    end else begin
      an_d = '1;
    end
    if (cur_hide_s) begin
      seg_d    = 7'h7F;
      seg_dp_d = 1'b1;
    end else begin
      seg_d    = ~bcd_to_seg(cur_dig_s);
      seg_dp_d = ~snap_dp_q[idx_q];
    end
  end

  // Scan counters, once-per-scan snapshot and registered pin drivers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      seg_q      <= 7'h7F;
      seg_dp_q   <= 1'b1;
      an_q       <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      an_q     <= an_d;
      if (snap_en_s) begin
        snap_dig_q <= digits;
        snap_dp_q  <= dp;
      end else begin
        snap_dig_q <= snap_dig_q;
        snap_dp_q  <= snap_dp_q;
      end
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign an     = an_q;

endmodule
